uart_tx_periph: RTL

Memory-mapped UART transmitter peripheral on the CPU peripheral bus, directly downstream of the data-memory/peripheral address decoder. The decoder supplies CE, PWE and a 2-bit register select, and muxes this block's prdata back to the CPU. The block holds a small TX FIFO, a programmable baud divider and an 8N1 serialiser driving the tx pin.

---
 rtl/uart_tx_periph.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with TX FIFO and programmable baud divider
// Ports: clk/reset (sync, active high); CE, PWE, addr[1:0], wdata[31:0] form the bus write;
// prdata[31:0] is the combinational register read for addr; tx is the serial line (idle high).
// Registers: 0 TXDATA (W push), 1 STATUS (busy/full/empty/ovf W1C/count), 2 BAUDDIV, 3 CTRL (en).
module uart_tx_periph #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CE,
  input  logic        PWE,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] prdata,
  output logic        tx
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e            state_q;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, en_q, en_d;
  logic [DIV_W-1:0]  div_q, div_d, cnt_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              wr, push, pop, accept, full, empty, bit_end;
  logic [2:0]        cnt_field;
  logic              unused_wdata;
  assign wr           = CE & PWE;
  assign push         = wr && addr == 2'd0;
  assign full         = count_q == CW'(FIFO_DEPTH);
  assign empty        = count_q == '0;
  assign pop          = state_q == IDLE && en_q && !empty;
  // a pop in the same cycle frees a slot, so a push into a full FIFO is still taken
  assign accept       = push && (!full || pop);
  // >= rather than == so a smaller BAUDDIV written mid-bit ends the bit at once
  assign bit_end      = cnt_q >= div_q;
  assign cnt_field    = (32'(count_q) > 32'd7) ? 3'd7 : 3'(count_q);
  assign tx           = tx_q;
  assign unused_wdata = &{1'b0, wdata};
  always_comb begin
    wptr_d  = accept ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + CW'(accept) - CW'(pop);
    ovf_d   = (push && !accept) || (ovf_q && !(wr && addr == 2'd1 && wdata[3]));
    en_d    = (wr && addr == 2'd3) ? wdata[0] : en_q;
    div_d   = (wr && addr == 2'd2) ? wdata[DIV_W-1:0] : div_q;
    prdata  = addr == 2'd1 ? {25'd0, cnt_field, ovf_q, empty, full, state_q != IDLE}
            : addr == 2'd2 ? 32'(div_q)
            : addr == 2'd3 ? {31'd0, en_q}
            : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b1;
      div_q   <= DIV_W'(DEFAULT_DIV);
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      div_q   <= div_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= wdata[7:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          shift_q <= mem_q[rptr_q];
          tx_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= START;
        end
        START: if (bit_end) begin
          state_q <= DATA;
          bit_q   <= '0;
          cnt_q   <= '0;
          tx_q    <= shift_q[0];
        end else cnt_q <= cnt_q + 1'b1;
        DATA: if (bit_end) begin
          cnt_q <= '0;
          if (bit_q == 3'd7) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            bit_q   <= bit_q + 1'b1;
            shift_q <= {1'b0, shift_q[7:1]};
            tx_q    <= shift_q[1];
          end
        end else cnt_q <= cnt_q + 1'b1;
        STOP: if (bit_end) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
